// File: rtl/slot_reel_sequencer.sv
// slot_reel_sequencer: spins three reels from the game FSM state, stops them
// one by one a fixed number of ticks apart, then scores the final symbols.
module slot_reel_sequencer #(
  parameter int SYMBOLS  = 10,
  parameter int STOP_GAP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic       tick,
  output logic [3:0] reel0,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic       spinning,
  output logic       win_flag,
  output logic       pair_flag,
  output logic       done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SPIN     = 3'd1;
  localparam logic [2:0] S_STOPPING = 3'd2;
  localparam logic [2:0] S_EVAL     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [1:0] G_SET  = 2'b00;
  localparam logic [1:0] G_RUN  = 2'b01;
  localparam logic [1:0] G_STOP = 2'b10;

  localparam logic [4:0] L_SYM      = 5'(SYMBOLS);
  localparam logic [7:0] L_GAP_LAST = 8'(STOP_GAP - 1);

  logic [2:0]      r_st;
  logic [2:0]      w_st_n;
  logic [2:0]      r_mask;
  logic [2:0]      w_mask_n;
  logic [7:0]      r_gap;
  logic [7:0]      w_gap_n;
  logic [2:0]      w_adv;
  logic [2:0][3:0] r_reel;
  logic            r_spin;
  logic            r_win;
  logic            r_pair;
  logic            r_done;
  logic            w_e01;
  logic            w_e12;
  logic            w_e02;
  logic            w_clr;

  function automatic logic [3:0] f_step(
    input logic [3:0] v,
    input logic [4:0] step
  );
    logic [4:0] s;
    s = {1'b0, v} + step;
    if (s >= L_SYM) s = s - L_SYM;
    return s[3:0];
  endfunction

  assign w_e01 = (r_reel[0] == r_reel[1]);
  assign w_e12 = (r_reel[1] == r_reel[2]);
  assign w_e02 = (r_reel[0] == r_reel[2]);
  assign w_clr = (r_st == S_DONE) &&
                 ((state == G_SET) || (state == G_RUN));

  always_comb begin
    w_st_n   = r_st;
    w_mask_n = r_mask;
    w_gap_n  = r_gap;
    w_adv    = 3'b000;
    case (r_st)
      S_IDLE: begin
        if (state == G_RUN) begin
          w_st_n   = S_SPIN;
          w_mask_n = 3'b111;
        end
      end
      S_SPIN: begin
        if (state == G_SET) begin
          w_st_n   = S_IDLE;
          w_mask_n = 3'b000;
        end else begin
          // a tick on the STOP edge still moves every reel
          if (tick) w_adv = r_mask;
          if (state == G_STOP) begin
            w_st_n   = S_STOPPING;
            w_mask_n = r_mask & 3'b110;
            w_gap_n  = 8'd0;
          end
        end
      end
      S_STOPPING: begin
        if (state == G_SET) begin
          w_st_n   = S_IDLE;
          w_mask_n = 3'b000;
        end else if (r_mask == 3'b000) begin
          w_st_n = S_EVAL;
        end else if (tick) begin
          if (r_gap == L_GAP_LAST) begin
            w_gap_n  = 8'd0;
            w_mask_n = r_mask[1] ? (r_mask & 3'b101) : 3'b000;
          end else begin
            w_gap_n = r_gap + 8'd1;
          end
          // the reel frozen on this tick must not move
          w_adv = w_mask_n;
        end
      end
      S_EVAL: begin
        w_st_n = S_DONE;
      end
      S_DONE: begin
        if (state == G_SET) begin
          w_st_n = S_IDLE;
        end else if (state == G_RUN) begin
          w_st_n   = S_SPIN;
          w_mask_n = 3'b111;
        end
      end
      default: begin
        w_st_n   = S_IDLE;
        w_mask_n = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= S_IDLE;
      r_mask <= 3'b000;
      r_gap  <= 8'd0;
      r_reel <= '0;
      r_spin <= 1'b0;
      r_win  <= 1'b0;
      r_pair <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_st   <= w_st_n;
      r_mask <= w_mask_n;
      r_gap  <= w_gap_n;
      r_spin <= |w_mask_n;
      for (int k = 0; k < 3; k++) begin
        if (w_adv[k]) r_reel[k] <= f_step(r_reel[k], 5'(k + 1));
      end
      if (r_st == S_EVAL) begin
        r_win  <= w_e01 & w_e12;
        r_pair <= (w_e01 ^ w_e12 ^ w_e02) & ~(w_e01 & w_e12);
        r_done <= 1'b1;
      end else if (w_clr) begin
        r_win  <= 1'b0;
        r_pair <= 1'b0;
        r_done <= 1'b0;
      end
    end
  end

  assign reel0     = r_reel[0];
  assign reel1     = r_reel[1];
  assign reel2     = r_reel[2];
  assign spinning  = r_spin;
  assign win_flag  = r_win;
  assign pair_flag = r_pair;
  assign done      = r_done;

endmodule

// File: tb/tb_slot_reel_sequencer.sv
// tb_slot_reel_sequencer: three reel sequencers (10/4, 9/4, 4/3) share one
// stimulus stream and are compared with a tick-counting reference model.
module tb_slot_reel_sequencer;

  localparam logic [1:0] G_SET  = 2'b00;
  localparam logic [1:0] G_RUN  = 2'b01;
  localparam logic [1:0] G_STOP = 2'b10;
  localparam logic [1:0] G_WIN  = 2'b11;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  logic       tick;
  logic [3:0] o_r0 [3];
  logic [3:0] o_r1 [3];
  logic [3:0] o_r2 [3];
  logic       o_spin [3];
  logic       o_win [3];
  logic       o_pair [3];
  logic       o_done [3];

  int total;
  int bad;

  slot_reel_sequencer #(.SYMBOLS(10), .STOP_GAP(4)) u_d10 (
    .clk(clk), .rst(rst), .state(state), .tick(tick),
    .reel0(o_r0[0]), .reel1(o_r1[0]), .reel2(o_r2[0]),
    .spinning(o_spin[0]), .win_flag(o_win[0]),
    .pair_flag(o_pair[0]), .done(o_done[0])
  );

  slot_reel_sequencer #(.SYMBOLS(9), .STOP_GAP(4)) u_d9 (
    .clk(clk), .rst(rst), .state(state), .tick(tick),
    .reel0(o_r0[1]), .reel1(o_r1[1]), .reel2(o_r2[1]),
    .spinning(o_spin[1]), .win_flag(o_win[1]),
    .pair_flag(o_pair[1]), .done(o_done[1])
  );

  slot_reel_sequencer #(.SYMBOLS(4), .STOP_GAP(3)) u_d4 (
    .clk(clk), .rst(rst), .state(state), .tick(tick),
    .reel0(o_r0[2]), .reel1(o_r1[2]), .reel2(o_r2[2]),
    .spinning(o_spin[2]), .win_flag(o_win[2]),
    .pair_flag(o_pair[2]), .done(o_done[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model: 0 idle, 1 spin, 2 stopping, 3 settling, 4 done
  int m_ph [3];
  int m_seed [3][3];
  int m_ns [3];
  int m_t [3];
  int m_w [3];
  bit m_win [3];
  bit m_pair [3];

  function automatic int sym(input int i);
    return (i == 0) ? 10 : ((i == 1) ? 9 : 4);
  endfunction

  function automatic int gap(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // reel k has moved once per spin tick plus the stop ticks before its stop
  function automatic int mreel(input int i, input int k);
    int adv;
    adv = m_ns[i];
    if (m_ph[i] >= 2) begin
      if (k == 1) adv = adv + imin(m_t[i], gap(i) - 1);
      if (k == 2) adv = adv + imin(m_t[i], 2 * gap(i) - 1);
    end
    return (m_seed[i][k] + (k + 1) * adv) % sym(i);
  endfunction

  function automatic logic [15:0] mexp(input int i);
    logic s;
    logic d;
    s = (m_ph[i] == 1) || (m_ph[i] == 2);
    d = (m_ph[i] == 4);
    return {4'(mreel(i, 0)), 4'(mreel(i, 1)), 4'(mreel(i, 2)),
            s, d & m_win[i], d & m_pair[i], d};
  endfunction

  function automatic logic [15:0] got_vec(input int i);
    return {o_r0[i], o_r1[i], o_r2[i],
            o_spin[i], o_win[i], o_pair[i], o_done[i]};
  endfunction

  function automatic logic [15:0] pk(
    input int a, input int b, input int c,
    input bit s, input bit w, input bit p, input bit d
  );
    return {4'(a), 4'(b), 4'(c), s, w, p, d};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ph[i] = 0;
      m_ns[i] = 0;
      m_t[i] = 0;
      m_w[i] = 0;
      m_win[i] = 0;
      m_pair[i] = 0;
      for (int k = 0; k < 3; k++) m_seed[i][k] = 0;
    end
  endtask

  task automatic fold(input int i);
    for (int k = 0; k < 3; k++) m_seed[i][k] = mreel(i, k);
    m_ns[i] = 0;
    m_t[i] = 0;
    m_win[i] = 0;
    m_pair[i] = 0;
  endtask

  task automatic model_edge(input logic [1:0] st, input logic tk);
    int a;
    int b;
    int c;
    for (int i = 0; i < 3; i++) begin
      case (m_ph[i])
        0: if (st == G_RUN) m_ph[i] = 1;
        1: begin
          if (st == G_SET) begin
            fold(i);
            m_ph[i] = 0;
          end else begin
            if (tk) m_ns[i]++;
            if (st == G_STOP) begin
              m_ph[i] = 2;
              m_t[i] = 0;
            end
          end
        end
        2: begin
          if (st == G_SET) begin
            fold(i);
            m_ph[i] = 0;
          end else if (tk) begin
            m_t[i]++;
            if (m_t[i] == 2 * gap(i)) begin
              m_ph[i] = 3;
              m_w[i] = 0;
            end
          end
        end
        3: begin
          m_w[i]++;
          if (m_w[i] == 2) begin
            a = mreel(i, 0);
            b = mreel(i, 1);
            c = mreel(i, 2);
            m_win[i] = (a == b) && (b == c);
            m_pair[i] = (int'(a == b) + int'(b == c) + int'(a == c)) == 1;
            m_ph[i] = 4;
          end
        end
        default: begin
          if (st == G_SET) begin
            fold(i);
            m_ph[i] = 0;
          end else if (st == G_RUN) begin
            fold(i);
            m_ph[i] = 1;
          end
        end
      endcase
    end
  endtask

  task automatic step(input logic [1:0] st, input logic tk);
    state = st;
    tick = tk;
    @(posedge clk);
    model_edge(st, tk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic bit all_ph(input int p);
    return (m_ph[0] == p) && (m_ph[1] == p) && (m_ph[2] == p);
  endfunction

  task automatic test_reset();
    logic [15:0] g;
    rst = 1'b1;
    state = G_RUN;
    tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      g = got_vec(i);
      total++;
      if (g !== 16'h0) begin
        bad++;
        $display("FAIL reset inst%0d got=%h exp=0000", i, g);
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_spin();
    logic [15:0] e;
    pulse_reset();
    step(G_RUN, 1'b1);
    e = pk(0, 0, 0, 1, 0, 0, 0);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL start_no_adv got=%h exp=%h", got_vec(0), e);
    end
    repeat (3) step(G_RUN, 1'b1);
    e = pk(3, 6, 9, 1, 0, 0, 0);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL spin_d10 got=%h exp=%h", got_vec(0), e);
    end
    e = pk(3, 6, 0, 1, 0, 0, 0);
    total++;
    if (got_vec(1) !== e) begin
      bad++;
      $display("FAIL spin_d9 got=%h exp=%h", got_vec(1), e);
    end
  endtask

  task automatic test_stop_no_win();
    logic [15:0] e;
    step(G_STOP, 1'b0);
    repeat (8) step(G_STOP, 1'b1);
    e = pk(3, 2, 0, 0, 0, 0, 0);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL stop_frozen got=%h exp=%h", got_vec(0), e);
    end
    repeat (2) step(G_STOP, 1'b0);
    e = pk(3, 2, 0, 0, 0, 0, 1);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL stop_done got=%h exp=%h", got_vec(0), e);
    end
  endtask

  task automatic test_jackpot();
    logic [15:0] e;
    pulse_reset();
    step(G_RUN, 1'b0);
    repeat (3) step(G_RUN, 1'b1);
    step(G_STOP, 1'b0);
    repeat (8) step(G_STOP, 1'b1);
    step(G_STOP, 1'b0);
    e = pk(3, 3, 3, 0, 0, 0, 0);
    total++;
    if (got_vec(1) !== e) begin
      bad++;
      $display("FAIL jackpot_early got=%h exp=%h", got_vec(1), e);
    end
    step(G_WIN, 1'b1);
    e = pk(3, 3, 3, 0, 1, 0, 1);
    total++;
    if (got_vec(1) !== e) begin
      bad++;
      $display("FAIL jackpot_win got=%h exp=%h", got_vec(1), e);
    end
    step(G_SET, 1'b0);
    e = pk(3, 3, 3, 0, 0, 0, 0);
    total++;
    if (got_vec(1) !== e) begin
      bad++;
      $display("FAIL jackpot_clear got=%h exp=%h", got_vec(1), e);
    end
  endtask

  task automatic test_pair();
    logic [15:0] e;
    pulse_reset();
    step(G_RUN, 1'b0);
    repeat (4) step(G_RUN, 1'b1);
    step(G_STOP, 1'b0);
    repeat (8) step(G_STOP, 1'b1);
    repeat (2) step(G_STOP, 1'b0);
    e = pk(4, 4, 3, 0, 0, 1, 1);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL pair got=%h exp=%h", got_vec(0), e);
    end
  endtask

  task automatic test_abort();
    logic [15:0] e;
    pulse_reset();
    step(G_RUN, 1'b0);
    repeat (3) step(G_RUN, 1'b1);
    step(G_STOP, 1'b0);
    repeat (2) step(G_STOP, 1'b1);
    e = pk(3, 0, 5, 1, 0, 0, 0);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL abort_pre got=%h exp=%h", got_vec(0), e);
    end
    step(G_SET, 1'b0);
    repeat (3) step(G_SET, 1'b1);
    e = pk(3, 0, 5, 0, 0, 0, 0);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL abort_hold got=%h exp=%h", got_vec(0), e);
    end
    step(G_RUN, 1'b0);
    step(G_RUN, 1'b1);
    e = pk(4, 2, 8, 1, 0, 0, 0);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL abort_reseed got=%h exp=%h", got_vec(0), e);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    pulse_reset();
    step(G_RUN, 1'b0);
    repeat (2) step(G_RUN, 1'b1);
    e = pk(2, 4, 6, 1, 0, 0, 0);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL async_pre got=%h exp=%h", got_vec(0), e);
    end
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_vec(i) !== 16'h0) begin
        bad++;
        $display("FAIL async_rst inst%0d got=%h exp=0000", i, got_vec(i));
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_wrap_simul();
    logic [15:0] e;
    pulse_reset();
    step(G_RUN, 1'b0);
    repeat (5) step(G_RUN, 1'b1);
    e = pk(1, 2, 3, 1, 0, 0, 0);
    total++;
    if (got_vec(2) !== e) begin
      bad++;
      $display("FAIL wrap_d4 got=%h exp=%h", got_vec(2), e);
    end
    step(G_STOP, 1'b1);
    e = pk(2, 0, 2, 1, 0, 0, 0);
    total++;
    if (got_vec(2) !== e) begin
      bad++;
      $display("FAIL simul_d4 got=%h exp=%h", got_vec(2), e);
    end
    e = pk(6, 2, 8, 1, 0, 0, 0);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL simul_d10 got=%h exp=%h", got_vec(0), e);
    end
    step(G_STOP, 1'b1);
    e = pk(6, 4, 1, 1, 0, 0, 0);
    total++;
    if (got_vec(0) !== e) begin
      bad++;
      $display("FAIL r0_frozen got=%h exp=%h", got_vec(0), e);
    end
  endtask

  task automatic test_random();
    int spin_left;
    int r;
    logic [1:0] st;
    logic tk;
    logic [15:0] e;
    logic [15:0] g;
    bit late;
    pulse_reset();
    spin_left = 0;
    for (int c = 0; c < 4000; c++) begin
      tk = 1'($urandom_range(0, 1));
      late = (m_ph[0] >= 3) || (m_ph[1] >= 3) || (m_ph[2] >= 3);
      if (all_ph(0)) begin
        r = int'($urandom_range(0, 5));
        st = (r == 0) ? G_SET : ((r == 1) ? G_WIN : G_RUN);
        spin_left = int'($urandom_range(0, 12));
      end else if (all_ph(1)) begin
        r = int'($urandom_range(0, 29));
        if (r == 0) st = G_SET;
        else if (spin_left > 0) st = (r < 8) ? G_WIN : G_RUN;
        else st = G_STOP;
        spin_left--;
      end else if (all_ph(4)) begin
        r = int'($urandom_range(0, 5));
        st = (r < 2) ? G_SET : ((r < 4) ? G_RUN : G_WIN);
        spin_left = int'($urandom_range(0, 12));
      end else if (all_ph(2) && ($urandom_range(0, 39) == 0)) begin
        st = G_SET;
      end else begin
        r = int'($urandom_range(0, 2));
        st = (r == 0) ? G_WIN : ((r == 1 && !late) ? G_RUN : G_STOP);
      end
      step(st, tk);
      for (int i = 0; i < 3; i++) begin
        e = mexp(i);
        g = got_vec(i);
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL rnd cyc=%0d inst%0d got=%h exp=%h", c, i, g, e);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    state = G_SET;
    tick = 1'b0;
    model_reset();
    test_reset();
    test_basic_spin();
    test_stop_no_win();
    test_jackpot();
    test_pair();
    test_abort();
    test_async_reset();
    test_wrap_simul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
